// File: rtl/pi_dpi_frame_tracker_if.sv
// Pi DPI raster pins in, qualified framing out; master drives the Pi-side pins
// and phase, slave is the tracker.
interface pi_dpi_frame_tracker_if;
  logic [2:0] sysClkPhase;
  logic       dpi_de;
  logic       dpi_vsync;
  logic       display_enable;
  logic       frame_start_flag;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       locked;

  modport master (
    output sysClkPhase, dpi_de, dpi_vsync,
    input  display_enable, frame_start_flag, pixel_x, pixel_y, locked
  );

  modport slave (
    input  sysClkPhase, dpi_de, dpi_vsync,
    output display_enable, frame_start_flag, pixel_x, pixel_y, locked
  );
endinterface

// File: rtl/pi_dpi_frame_tracker.sv
// Recovers Pi DPI framing (display enable, frame start, pixel coords, lock) on sysClk.
// Latency 3..10 sysClk from a dpi_de pin edge; no backpressure, outputs move only on strobe edges.
module pi_dpi_frame_tracker #(
  parameter int         ACTIVE_W    = 720,
  parameter int         ACTIVE_H    = 576,
  parameter logic [2:0] PIXEL_PHASE = 3'd0,
  parameter int         LOCK_FRAMES = 2,
  parameter logic       VSYNC_POL   = 1'b0
) (
  input  logic                  sysClk,
  input  logic                  nReset,
  pi_dpi_frame_tracker_if.slave dpi
);
  localparam logic [9:0] X_MAX  = 10'(ACTIVE_W - 1);
  localparam logic [9:0] Y_MAX  = 10'(ACTIVE_H - 1);
  localparam logic [2:0] LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  logic       de_meta_q, de_sync_q, vs_meta_q, vs_sync_q;
  logic       de_prev_q, de_prev_d, vs_prev_q, vs_prev_d;
  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d, bad_q, bad_d;
  logic [2:0] good_q, good_d, good_inc;
  logic       locked_q, locked_d, de_en_q, de_en_d, fsf_q, fsf_d;
  logic       strobe, vs_act, de_rise, de_fall, vs_edge, frame_end, frame_good;

  assign strobe   = (dpi.sysClkPhase == PIXEL_PHASE);
  assign vs_act   = (vs_sync_q == VSYNC_POL);
  assign de_rise  = de_sync_q & ~de_prev_q;
  assign de_fall  = ~de_sync_q & de_prev_q;
  assign vs_edge  = vs_act & ~vs_prev_q;
  assign good_inc = (good_q == LOCK_N) ? good_q : good_q + 3'd1;

  // vsync synchroniser resets to its inactive level so release never fakes an edge
  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      de_meta_q <= 1'b0;
      de_sync_q <= 1'b0;
      vs_meta_q <= ~VSYNC_POL;
      vs_sync_q <= ~VSYNC_POL;
    end else begin
      de_meta_q <= dpi.dpi_de;
      de_sync_q <= de_meta_q;
      vs_meta_q <= dpi.dpi_vsync;
      vs_sync_q <= vs_meta_q;
    end
  end

  always_comb begin
    de_prev_d  = de_prev_q;
    vs_prev_d  = vs_prev_q;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    x_ovf_d    = x_ovf_q;
    y_ovf_d    = y_ovf_q;
    bad_d      = bad_q;
    good_d     = good_q;
    locked_d   = locked_q;
    de_en_d    = de_en_q;
    fsf_d      = 1'b0;
    frame_end  = 1'b0;
    frame_good = 1'b0;
    if (strobe) begin
      de_prev_d = de_sync_q;
      vs_prev_d = vs_act;
      case (state_q)
        IDLE: if (vs_edge) state_d = ARMED;
        ARMED: begin
          if (vs_edge) begin
            frame_end = 1'b1;
          end else if (de_rise) begin
            state_d = ACTIVE;
            fsf_d   = 1'b1;
            x_d     = '0;
            y_d     = '0;
            x_ovf_d = 1'b0;
            y_ovf_d = 1'b0;
            bad_d   = 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_edge) begin
            // a line still open (or just closing) at vsync is never a good frame
            frame_end  = 1'b1;
            frame_good = !bad_q && !de_sync_q && !de_prev_q && (y_q == Y_MAX) && !y_ovf_q;
            state_d    = ARMED;
          end else if (de_rise) begin
            x_d     = '0;
            x_ovf_d = 1'b0;
            if (y_q == Y_MAX) begin
              y_ovf_d = 1'b1;
              bad_d   = 1'b1;
            end else begin
              y_d = y_q + 10'd1;
            end
          end else if (de_sync_q) begin
            if (x_q == X_MAX) begin
              x_ovf_d = 1'b1;
              bad_d   = 1'b1;
            end else begin
              x_d = x_q + 10'd1;
            end
          end else if (de_fall) begin
            if (x_q != X_MAX || x_ovf_q) bad_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (frame_end) begin
        if (frame_good) begin
          good_d   = good_inc;
          locked_d = (good_inc == LOCK_N);
        end else begin
          good_d   = '0;
          locked_d = 1'b0;
        end
      end
      de_en_d = de_sync_q && (state_d == ACTIVE) && !x_ovf_d && !y_ovf_d && locked_d;
    end
  end

  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x_ovf_q   <= 1'b0;
      y_ovf_q   <= 1'b0;
      bad_q     <= 1'b0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      de_en_q   <= 1'b0;
      fsf_q     <= 1'b0;
    end else begin
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_ovf_q   <= x_ovf_d;
      y_ovf_q   <= y_ovf_d;
      bad_q     <= bad_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      de_en_q   <= de_en_d;
      fsf_q     <= fsf_d;
    end
  end

  assign dpi.display_enable   = de_en_q;
  assign dpi.frame_start_flag = fsf_q;
  assign dpi.pixel_x          = x_q;
  assign dpi.pixel_y          = y_q;
  assign dpi.locked           = locked_q;
endmodule

// File: tb/tb_pi_dpi_frame_tracker.sv
// Directed bench for pi_dpi_frame_tracker on a reduced 6x4 raster, strobe phase 3.
module tb_pi_dpi_frame_tracker;
  localparam int         W        = 6;
  localparam int         H        = 4;
  localparam logic [2:0] PH       = 3'd3;
  localparam logic [2:0] CHG_PH   = 3'd4;
  localparam int         FRAME_DE = 8 * W * H;

  logic       sysClk = 1'b0;
  logic       nReset = 1'b0;
  logic [2:0] ph     = 3'd0;
  int         cyc    = 0;

  pi_dpi_frame_tracker_if dif();
  assign dif.sysClkPhase = ph;

  pi_dpi_frame_tracker #(
    .ACTIVE_W(W), .ACTIVE_H(H), .PIXEL_PHASE(PH), .LOCK_FRAMES(2), .VSYNC_POL(1'b0)
  ) dut (
    .sysClk(sysClk),
    .nReset(nReset),
    .dpi   (dif)
  );

  always #5 sysClk = ~sysClk;

  always @(posedge sysClk) begin
    ph  <= ph + 3'd1;
    cyc <= cyc + 1;
  end

  int   de_cycles = 0, fsf_cnt = 0, fsf_long = 0, fsf_xy_bad = 0, phase_err = 0;
  int   rise_cyc = 0, fall_cyc = 0, max_x = 0, max_y = 0;
  logic de_last = 1'b0, fsf_last = 1'b0, rst_last = 1'b0;

  // Observes outputs mid-cycle; display_enable may only move on the edge after the strobe
  always @(negedge sysClk) begin
    if (dif.display_enable) de_cycles <= de_cycles + 1;
    if (dif.display_enable !== de_last) begin
      if (nReset && rst_last && dif.sysClkPhase !== CHG_PH) phase_err <= phase_err + 1;
      if (dif.display_enable) rise_cyc <= cyc;
      else fall_cyc <= cyc;
    end
    if (dif.frame_start_flag) begin
      fsf_cnt <= fsf_cnt + 1;
      if (fsf_last) fsf_long <= fsf_long + 1;
      if (dif.pixel_x != 10'd0 || dif.pixel_y != 10'd0) fsf_xy_bad <= fsf_xy_bad + 1;
    end
    if (int'(dif.pixel_x) > max_x) max_x <= int'(dif.pixel_x);
    if (int'(dif.pixel_y) > max_y) max_y <= int'(dif.pixel_y);
    de_last  <= dif.display_enable;
    fsf_last <= dif.frame_start_flag;
    rst_last <= nReset;
  end

  int chk = 0;
  int err = 0;
  int t_rise = 0, t_fall = 0;

  task automatic check(input string tag, input int obs, input int exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel period: drive pins, hold for 8 sysClk, return 1 time unit after an edge
  task automatic pix(input logic de, input logic vs);
    dif.dpi_de    = de;
    dif.dpi_vsync = vs;
    repeat (8) @(posedge sysClk);
    #1;
  endtask

  task automatic line(input int len);
    t_rise = cyc;
    for (int p = 0; p < len; p++) pix(1'b1, 1'b1);
    t_fall = cyc;
    pix(1'b0, 1'b1);
    pix(1'b0, 1'b1);
  endtask

  task automatic vsync();
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b1);
    pix(1'b0, 1'b1);
  endtask

  task automatic frame(input int lines, input int len, input int short_idx);
    for (int l = 0; l < lines; l++) line((l == short_idx) ? len - 1 : len);
    vsync();
  endtask

  initial begin
    int d0, f0, lat_r, lat_f;
    dif.dpi_de    = 1'b0;
    dif.dpi_vsync = 1'b1;
    repeat (3) @(posedge sysClk);
    #1;
    check("rst_de", int'(dif.display_enable), 0);
    check("rst_fsf", int'(dif.frame_start_flag), 0);
    check("rst_x", int'(dif.pixel_x), 0);
    check("rst_y", int'(dif.pixel_y), 0);
    check("rst_locked", int'(dif.locked), 0);
    nReset = 1'b1;

    // Ideal raster: lock after the third vsync, then one fully enabled frame
    d0 = de_cycles; f0 = fsf_cnt;
    vsync();
    frame(H, W, -1);
    check("ideal_locked_v2", int'(dif.locked), 0);
    frame(H, W, -1);
    check("ideal_locked_v3", int'(dif.locked), 1);
    check("ideal_de_unlocked", de_cycles - d0, 0);
    check("ideal_fsf_f12", fsf_cnt - f0, 2);
    d0 = de_cycles; f0 = fsf_cnt;
    frame(H, W, -1);
    check("ideal_de_f3", de_cycles - d0, FRAME_DE);
    check("ideal_fsf_f3", fsf_cnt - f0, 1);
    check("ideal_fsf_len", fsf_long, 0);
    check("ideal_fsf_xy", fsf_xy_bad, 0);
    check("ideal_max_x", max_x, W - 1);
    check("ideal_max_y", max_y, H - 1);
    check("ideal_locked_f3", int'(dif.locked), 1);

    // Phase sweep: cumulative shifts 0,1,3,6,10,15,21,28 visit every phase mod 8
    for (int k = 0; k < 8; k++) begin
      repeat (k) begin
        @(posedge sysClk);
        #1;
      end
      line(W);
      lat_r = rise_cyc - t_rise;
      lat_f = fall_cyc - t_fall;
      check("lat_rise_range", int'(lat_r >= 3 && lat_r <= 10), 1);
      check("lat_fall_range", int'(lat_f >= 3 && lat_f <= 10), 1);
      check("lat_same", lat_r, lat_f);
      for (int l = 1; l < H; l++) line(W);
      vsync();
    end
    check("sweep_phase", phase_err, 0);
    check("sweep_locked", int'(dif.locked), 1);

    // Short line breaks lock; two good frames needed before enable returns
    frame(H, W, 1);
    check("short_locked", int'(dif.locked), 0);
    d0 = de_cycles;
    frame(H, W, -1);
    check("short_relock1", int'(dif.locked), 0);
    frame(H, W, -1);
    check("short_relock2", int'(dif.locked), 1);
    check("short_de_off", de_cycles - d0, 0);
    d0 = de_cycles;
    frame(H, W, -1);
    check("short_de_back", de_cycles - d0, FRAME_DE);

    // Long raster: saturating coordinates, excess pixel and line not enabled
    d0 = de_cycles;
    frame(H + 1, W + 1, -1);
    check("long_de", de_cycles - d0, FRAME_DE);
    check("long_max_x", max_x, W - 1);
    check("long_max_y", max_y, H - 1);
    check("long_locked", int'(dif.locked), 0);
    frame(H, W, -1);
    frame(H, W, -1);
    check("long_relock", int'(dif.locked), 1);

    // Vsync with de high mid-line
    line(W);
    line(W);
    for (int p = 0; p < 4; p++) pix(1'b1, 1'b1);
    pix(1'b1, 1'b0);
    pix(1'b1, 1'b1);
    pix(1'b0, 1'b1);
    pix(1'b0, 1'b1);
    check("mid_locked", int'(dif.locked), 0);
    check("mid_y_before", int'(dif.pixel_y), 2);
    f0 = fsf_cnt;
    line(W);
    check("mid_fsf", fsf_cnt - f0, 1);
    check("mid_fsf_xy", fsf_xy_bad, 0);
    check("mid_x", int'(dif.pixel_x), W - 1);
    check("mid_y", int'(dif.pixel_y), 0);
    for (int l = 1; l < H; l++) line(W);
    vsync();
    frame(H, W, -1);
    check("mid_relock", int'(dif.locked), 1);

    // Reset mid-frame while enabled
    line(W);
    line(W);
    pix(1'b1, 1'b1);
    pix(1'b1, 1'b1);
    pix(1'b1, 1'b1);
    check("rmf_pre_de", int'(dif.display_enable), 1);
    check("rmf_pre_locked", int'(dif.locked), 1);
    nReset = 1'b0;
    #1;
    check("rmf_de", int'(dif.display_enable), 0);
    check("rmf_fsf", int'(dif.frame_start_flag), 0);
    check("rmf_x", int'(dif.pixel_x), 0);
    check("rmf_y", int'(dif.pixel_y), 0);
    check("rmf_locked", int'(dif.locked), 0);
    pix(1'b0, 1'b1);
    pix(1'b0, 1'b1);
    nReset = 1'b1;
    d0 = de_cycles;
    vsync();
    frame(H, W, -1);
    frame(H, W, -1);
    check("rmf_relock", int'(dif.locked), 1);
    check("rmf_de_off", de_cycles - d0, 0);
    d0 = de_cycles;
    frame(H, W, -1);
    check("rmf_de_back", de_cycles - d0, FRAME_DE);
    check("final_phase", phase_err, 0);
    check("final_fsf_len", fsf_long, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule

// File: doc/pi_dpi_frame_tracker.md
# pi_dpi_frame_tracker

Recovers the Raspberry Pi DPI output framing (active-area display enable, start-of-frame flag and active pixel coordinates) inside the sysClk domain. It sits directly upstream of aivvideo and drives its displayEnable_pi and frame_start_flag_pi inputs, which set when the framebuffer read side fetches pixels. It also qualifies the Pi raster with a lock detector, so a mis-configured or unstable Pi mode never drives framebuffer reads.

## Interface
- ACTIVE_W, 720: active pixels per line.
- ACTIVE_H, 576: active lines per frame.
- PIXEL_PHASE, 3'd0: sysClkPhase value that marks the pixel sample cycle.
- LOCK_FRAMES, 2: consecutive good frames required to assert locked (1..7).
- VSYNC_POL, 1'b0: active level of dpi_vsync.
- sysClk  in  1  system clock; the sole clock.
- nReset  in  1  asynchronous, active-low reset.
- sysClkPhase  in  3  free-running phase counter; the pixel strobe is sysClkPhase == PIXEL_PHASE.
- dpi_de  in  1  Pi DPI data enable, asynchronous to sysClk.
- dpi_vsync  in  1  Pi DPI vsync, asynchronous to sysClk.
- display_enable  out  1  active-high when the sample is inside the qualified active window (feeds displayEnable_pi).
- frame_start_flag  out  1  one-sysClk pulse at the first active pixel of a frame (feeds frame_start_flag_pi).
- pixel_x  out  10  active pixel index, 0..ACTIVE_W-1.
- pixel_y  out  10  active line index, 0..ACTIVE_H-1.
- locked  out  1  Pi raster geometry confirmed.

## Operation
- Synchronisation:
  - dpi_de and dpi_vsync each pass through a 2-flop synchroniser on sysClk.
  - All tracking logic advances only on strobe cycles. The previous synchronised value of each input is kept for edge detection.
- Vsync:
  - An active-going edge of dpi_vsync ends the current frame.
  - The frame is judged good if exactly ACTIVE_H lines were seen and every line was exactly ACTIVE_W pixels.
  - The state then moves to ARMED.
- State machine, three states:
  - IDLE, the reset state: waits for a vsync edge, then moves to ARMED. No frame is judged on this first edge.
  - ARMED: the first dpi_de rising edge starts the frame. frame_start_flag pulses, pixel_x=0, pixel_y=0, and the state moves to ACTIVE.
  - ACTIVE: counts pixels and lines as described below.
- Pixel and line counting in ACTIVE:
  - Each strobe with de=1 after the first increments pixel_x.
  - A de rising edge (other than the frame-start one) sets pixel_x=0 and increments pixel_y.
  - A de falling edge records whether the line length equalled ACTIVE_W; any mismatch sets the frame-bad flag.
- Overflow:
  - pixel_x saturates at ACTIVE_W-1 and pixel_y saturates at ACTIVE_H-1. Either overflow sets frame-bad.
  - Pixels past ACTIVE_W and lines past ACTIVE_H are not display-enabled.
- Vsync while de=1 mid-line: the line is abandoned, the frame is marked bad, and the state goes to ARMED.
- Lock:
  - A 3-bit good-frame counter increments on each good frame and saturates at LOCK_FRAMES.
  - Any bad frame clears both the counter and locked.
  - locked asserts when the counter reaches LOCK_FRAMES.
- display_enable = synchronised de AND state ACTIVE AND in-window AND locked.
- frame_start_flag is generated regardless of locked, so the framebuffer read pointer still resets while lock is being acquired.

## Timing
- Reset values: display_enable=0, frame_start_flag=0, pixel_x=0, pixel_y=0, locked=0, state IDLE, good-frame counter 0.
- Reset asserted mid-frame:
  - All outputs drop immediately, asynchronously.
  - After release the block waits in IDLE for the next vsync, so at least LOCK_FRAMES+1 vsyncs occur before display_enable can assert.
- Output update:
  - display_enable, pixel_x, pixel_y and locked are registered and change only on the sysClk edge ending a strobe cycle.
  - They are held for the 8 cycles between strobes.
- frame_start_flag is high for exactly one sysClk cycle, coincident with the first cycle of pixel (0,0) on display_enable.
- Latency: a pin change on dpi_de reaches display_enable after 2 sync cycles plus 1–8 cycles of strobe alignment, i.e. 3–10 sysClk cycles. This latency is fixed per edge and identical for rising and falling edges.
- locked rises on the strobe edge that processes the qualifying vsync edge, and falls on the strobe edge that judges a bad frame.
- Arithmetic: all counters are unsigned 10-bit; there is no wrap-around past the saturation limits.

## Test plan
- Ideal raster: 720×576 de raster with vsync every 625 lines, 3 frames. Required: locked=1 after the 3rd vsync; in frame 3, display_enable high exactly 414720 strobes; frame_start_flag exactly one 1-cycle pulse per frame; pixel_x runs 0..719 and pixel_y 0..575.
- Short line: once locked, one line of 719 pixels. Required: at the next vsync locked=0 and the counter cleared; display_enable stays low until 2 further good frames complete.
- Long raster: 721-pixel lines and 577 lines. Required: pixel_x holds at 719 and pixel_y at 575; display_enable low for the excess pixel and line; the frame is judged bad.
- Mid-line vsync: vsync asserted at line 300, pixel 400, with de=1. Required: the state goes to ARMED, locked drops, and the next de rising edge pulses frame_start_flag with pixel_x=0, pixel_y=0.
- Reset mid-frame: nReset pulled low at line 100 while locked. Required: all outputs 0 within the same cycle; after release, display_enable stays low until 3 vsyncs have passed.
- Phase alignment: sweep the de edge across all 8 sysClkPhase values with PIXEL_PHASE=3. Required: display_enable transitions only on the edge after phase 3, with latency in 3..10 cycles.
